// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port (f_*) and the data port (d_*). One transaction is outstanding at a time,
// the data port has fixed priority, and every output is registered.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive data
// grants made while fetch waits, the next contended grant goes to fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_W-1:0]     f_addr,
  output logic                  f_done,
  output logic [DATA_W-1:0]     f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 3;

  // Elaboration-time parameter sanity: counter is 3 bits, strobes are per byte
  if (STARVE_MAX > 7) begin : g_bad_starve_max
    $error("STARVE_MAX must fit in the 3-bit starvation counter");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Winner of the current transaction: 1 = data port, 0 = fetch port
  logic win_d;

  logic grant_d;
  logic grant_f;

  logic              mem_req_nx;
  logic              mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic [STRB_W-1:0] mem_wstrb_nx;
  logic              win_d_nx;
  logic              f_done_nx;
  logic              d_done_nx;
  logic [DATA_W-1:0] f_rdata_nx;
  logic [DATA_W-1:0] d_rdata_nx;
  logic              busy_nx;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

  // Grant selection: data wins unless fetch has been starved long enough
  always_comb begin
    grant_d = d_req && !(starve_hit && f_req);
    grant_f = f_req && !grant_d;
  end

  // Saturating count of data grants made while fetch was waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_f || !f_req) begin
        starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != {CNT_W{1'b1}})) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  // Grant selection: strict data-port priority
  always_comb begin
    grant_d = d_req;
    grant_f = f_req && !d_req;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: IDLE -> BUSY on grant, BUSY -> DONE on ack, DONE -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_d || grant_f) state_nx = BUSY;
      BUSY:    if (mem_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values for the registered memory, done and busy outputs
  always_comb begin
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    mem_wstrb_nx = mem_wstrb;
    win_d_nx     = win_d;
    f_done_nx    = 1'b0;
    d_done_nx    = 1'b0;
    f_rdata_nx   = '0;
    d_rdata_nx   = '0;
    busy_nx      = (state_nx != IDLE);
    case (state)
      IDLE: begin
        if (grant_d) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = d_we;
          mem_addr_nx  = d_addr;
          mem_wdata_nx = d_wdata;
          mem_wstrb_nx = d_we ? d_wstrb : '0;
          win_d_nx     = 1'b1;
        end else if (grant_f) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = f_addr;
          mem_wdata_nx = '0;
          mem_wstrb_nx = '0;
          win_d_nx     = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_nx = 1'b0;
          if (win_d) begin
            d_done_nx  = 1'b1;
            d_rdata_nx = mem_we ? '0 : mem_rdata;
          end else begin
            f_done_nx  = 1'b1;
            f_rdata_nx = mem_rdata;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output and latch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      win_d     <= 1'b0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_wstrb <= mem_wstrb_nx;
      win_d     <= win_d_nx;
      f_done    <= f_done_nx;
      d_done    <= d_done_nx;
      f_rdata   <= f_rdata_nx;
      d_rdata   <= d_rdata_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple memory model
// whose ack latency is programmable (or tied straight to mem_req).
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_done;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_lat cycles of mem_req, or same cycle when zero_wait
  logic              zero_wait = 1'b0;
  int                ack_lat   = 1;
  int                wait_cnt;
  logic [DATA_W-1:0] rdata_val = '0;

  assign mem_ack   = zero_wait ? mem_req : (mem_req && (wait_cnt >= ack_lat));
  assign mem_rdata = mem_ack ? rdata_val : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Monitor: pulse counts, exclusivity, rdata-zero rule, grant log
  int   f_pulses  = 0;
  int   d_pulses  = 0;
  int   both_err  = 0;
  int   rdata_err = 0;
  logic log_en    = 1'b0;
  byte  log_q[$];

  always @(negedge clk) begin
    if (f_done && d_done) both_err++;
    if ((!f_done && f_rdata != '0) || (!d_done && d_rdata != '0)) rdata_err++;
    if (f_done) f_pulses++;
    if (d_done) d_pulses++;
    if (log_en && f_done) log_q.push_back(8'h46);
    if (log_en && d_done) log_q.push_back(8'h44);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if ({f_done, d_done} !== 2'b00) begin bad++; $display("FAIL reset_done got=%0b exp=00", {f_done, d_done}); end
    total++; if ({mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL reset_mem_bus got=%0h exp=0", {mem_we, mem_wstrb, mem_addr, mem_wdata}); end
    total++; if ({f_rdata, d_rdata} !== '0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", {f_rdata, d_rdata}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    int  n;
    bit  got;
    ack_lat = 2; rdata_val = 32'hDEADBEEF;
    f_addr = 32'h100; f_req = 1'b1;
    tick();
    total++; if (mem_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL fetch_issue got req=%0b busy=%0b exp=1,1", mem_req, busy); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_mem_addr got=%0h exp=100", mem_addr); end
    total++; if (mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin bad++; $display("FAIL fetch_mem_we got we=%0b strb=%0h exp=0,0", mem_we, mem_wstrb); end
    n = 1; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (f_done || d_done) begin got = 1'b1; break; end
    end
    total++; if (!got || n != 4) begin bad++; $display("FAIL fetch_latency got=%0d (seen=%0b) exp=4", n, got); end
    total++; if (f_done !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL fetch_done got f=%0b d=%0b exp=1,0", f_done, d_done); end
    total++; if (f_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%0h exp=deadbeef", f_rdata); end
    f_req = 1'b0;
    tick();
    total++; if (f_done !== 1'b0 || f_rdata !== '0 || busy !== 1'b0) begin bad++; $display("FAIL fetch_after got done=%0b rdata=%0h busy=%0b exp=0,0,0", f_done, f_rdata, busy); end
  endtask

  task automatic test_simultaneous();
    int n;
    bit got;
    ack_lat = 1; rdata_val = 32'hBAD0BAD0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    f_req = 1'b1; f_addr = 32'h104;
    tick();
    total++; if (mem_we !== 1'b1 || mem_wstrb !== 4'hF) begin bad++; $display("FAIL simul_store_ctl got we=%0b strb=%0h exp=1,f", mem_we, mem_wstrb); end
    total++; if (mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin bad++; $display("FAIL simul_store_bus got addr=%0h data=%0h exp=200,12345678", mem_addr, mem_wdata); end
    d_addr = 32'hFFFFFFF0; d_wdata = '0; d_wstrb = 4'h0;
    tick();
    total++; if (mem_addr !== 32'h200 || mem_wdata !== 32'h12345678 || mem_req !== 1'b1) begin bad++; $display("FAIL simul_latched got addr=%0h data=%0h req=%0b exp=200,12345678,1", mem_addr, mem_wdata, mem_req); end
    tick();
    total++; if (d_done !== 1'b1 || f_done !== 1'b0) begin bad++; $display("FAIL simul_d_first got d=%0b f=%0b exp=1,0", d_done, f_done); end
    total++; if (d_rdata !== '0) begin bad++; $display("FAIL simul_store_rdata got=%0h exp=0", d_rdata); end
    d_req = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (f_done || d_done) begin got = 1'b1; break; end
    end
    total++; if (!got || n != 4 || f_done !== 1'b1) begin bad++; $display("FAIL simul_f_later got=%0d f=%0b (seen=%0b) exp=4,1", n, f_done, got); end
    total++; if (f_rdata !== 32'hBAD0BAD0) begin bad++; $display("FAIL simul_f_rdata got=%0h exp=bad0bad0", f_rdata); end
    f_req = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait();
    zero_wait = 1'b1; rdata_val = 32'hCAFEF00D;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zw_idle_busy got=%0b exp=0", busy); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h11111111; d_wstrb = 4'hF;
    tick();
    total++; if (mem_req !== 1'b1 || busy !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL zw_t1 got req=%0b busy=%0b done=%0b exp=1,1,0", mem_req, busy, d_done); end
    total++; if (mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h300) begin bad++; $display("FAIL zw_load_bus got we=%0b strb=%0h addr=%0h exp=0,0,300", mem_we, mem_wstrb, mem_addr); end
    tick();
    total++; if (mem_req !== 1'b0 || busy !== 1'b1 || d_done !== 1'b1) begin bad++; $display("FAIL zw_t2 got req=%0b busy=%0b done=%0b exp=0,1,1", mem_req, busy, d_done); end
    total++; if (d_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL zw_rdata got=%0h exp=cafef00d", d_rdata); end
    d_req = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || d_done !== 1'b0) begin bad++; $display("FAIL zw_t3 got busy=%0b done=%0b exp=0,0", busy, d_done); end
    zero_wait = 1'b0;
  endtask

  task automatic test_reset_mid();
    int  p0;
    int  n;
    bit  got;
    ack_lat = 5; rdata_val = 32'h0BADF00D;
    p0 = f_pulses;
    f_addr = 32'h400; f_req = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%0b exp=1", busy); end
    tick();
    rst = 1'b1; f_req = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || busy !== 1'b0 || f_done !== 1'b0) begin bad++; $display("FAIL rmid_async got req=%0b busy=%0b done=%0b exp=0,0,0", mem_req, busy, f_done); end
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0 || f_pulses != p0) begin bad++; $display("FAIL rmid_no_done got busy=%0b pulses=%0d exp=0,%0d", busy, f_pulses, p0); end
    ack_lat = 1; rdata_val = 32'h55AA55AA;
    f_addr = 32'h500; f_req = 1'b1;
    tick();
    total++; if (mem_addr !== 32'h500 || mem_req !== 1'b1) begin bad++; $display("FAIL rmid_new_issue got addr=%0h req=%0b exp=500,1", mem_addr, mem_req); end
    n = 1; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (f_done || d_done) begin got = 1'b1; break; end
    end
    total++; if (!got || n != 3 || f_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL rmid_new_done got n=%0d rdata=%0h (seen=%0b) exp=3,55aa55aa", n, f_rdata, got); end
    f_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int  start;
    byte exp_seq [6];
`ifdef ARB_STARVE_GUARD_EN
    exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h46, 8'h44};
`else
    exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
`endif
    ack_lat = 0; rdata_val = 32'h00000001;
    start = log_q.size();
    log_en = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; f_req = 1'b1; f_addr = 32'h700;
    repeat (18) tick();
    log_en = 1'b0;
    d_req = 1'b0; f_req = 1'b0;
    total++; if (log_q.size() - start != 6) begin bad++; $display("FAIL starve_count got=%0d exp=6", log_q.size() - start); end
    for (int i = 0; i < 6; i++) begin
      if (start + i < log_q.size()) begin
        total++;
        if (log_q[start + i] !== exp_seq[i]) begin bad++; $display("FAIL starve_grant%0d got=%c exp=%c", i, log_q[start + i], exp_seq[i]); end
      end
    end
    repeat (4) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL starve_drain got busy=%0b exp=0", busy); end
  endtask

  task automatic test_exclusive();
    total++; if (both_err != 0) begin bad++; $display("FAIL both_done got=%0d exp=0", both_err); end
    total++; if (rdata_err != 0) begin bad++; $display("FAIL rdata_when_idle got=%0d exp=0", rdata_err); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_zero_wait();
    test_reset_mid();
    test_starvation();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
